fnd_scan_controller: RTL and testbench

//  - Time-multiplexes a 4-digit common-anode FND. Splits a binary count (0..9999) into BCD digits.
//  - Each frame drives one digit per slot: active-low digit select, 4-bit digit code, blank flag.
//  - Sits directly upstream of the BCD-to-FND font decoder. o_value/o_onOff feed its i_value/i_onOff.
//  - Inserts a dead-time blank at the start of every slot to suppress ghosting.

---
 rtl/fnd_scan_controller_if.sv | 25 ++
 rtl/fnd_scan_controller.sv | 115 +++++++++++
 tb/tb_fnd_scan_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fnd_scan_controller_if.sv
// Display-side bundle of the FND scan controller: value/enable in, digit
// select and decoder code out.
interface fnd_scan_controller_if;
  logic [13:0] i_value;
  logic        i_onOff;
  logic [3:0]  o_digit_sel;
  logic [3:0]  o_value;
  logic        o_onOff;

  modport master (
    output i_value,
    output i_onOff,
    input  o_digit_sel,
    input  o_value,
    input  o_onOff
  );

  modport slave (
    input  i_value,
    input  i_onOff,
    output o_digit_sel,
    output o_value,
    output o_onOff
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Four-digit common-anode FND scanner. Snapshots the value once per frame,
// splits it into BCD digits and drives one digit per slot, blanking the start
// of every slot to suppress ghosting.
// Optional macro FND_LEAD_ZERO_BLANK_EN: blank leading zero digits.
//
// state | meaning
// ------+------------------------------------------------------------
// BLANK | dead-time at start of slot, outputs blank
// DRIVE | selected digit driven with its code
module fnd_scan_controller #(
  parameter int P_SCAN_DIV     = 100_000,
  parameter int P_BLANK_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  fnd_scan_controller_if.slave  bus
);

  localparam int CNT_W = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(P_SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(P_BLANK_CYCLES - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [13:0]      snap_q;
  logic [3:0]       sel_q, val_q;
  logic             off_q;

  logic [3:0] dig0, dig1, dig2, dig3;
  logic       ovf;
  logic [3:0] drv_val;
  logic       drv_off;

  // Slot counter and digit index advance every cycle.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  assign dig0 = 4'(snap_q % 14'd10);
  assign dig1 = 4'((snap_q / 14'd10) % 14'd10);
  assign dig2 = 4'((snap_q / 14'd100) % 14'd10);
  assign dig3 = 4'(snap_q / 14'd1000);
  assign ovf  = (snap_q > 14'd9999);

  // Code and blank flag for the digit currently being scanned.
  always_comb begin
    drv_off = 1'b0;
    case (idx_q)
      2'd0:    drv_val = dig0;
      2'd1:    drv_val = dig1;
      2'd2:    drv_val = dig2;
      default: drv_val = dig3;
    endcase
    if (ovf) drv_val = 4'ha;
`ifdef FND_LEAD_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher digit are zero;
    // the ones digit always shows so a value of 0 reads "0".
    if (!ovf) begin
      case (idx_q)
        2'd1:    drv_off = (dig3 == 4'd0) && (dig2 == 4'd0) && (dig1 == 4'd0);
        2'd2:    drv_off = (dig3 == 4'd0) && (dig2 == 4'd0);
        2'd3:    drv_off = (dig3 == 4'd0);
        default: drv_off = 1'b0;
      endcase
    end
`endif
  end

  // Scan FSM, frame snapshot and registered display outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      sel_q   <= 4'hf;
      val_q   <= 4'h0;
      off_q   <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (idx_q == 2'd0 && cnt_q == '0) snap_q <= bus.i_value;

      case (state_q)
        BLANK:   if (cnt_q == BLANK_LAST) state_q <= DRIVE;
        DRIVE:   if (cnt_q == CNT_LAST)   state_q <= BLANK;
        default: state_q <= BLANK;
      endcase

      // Display-off only masks the outputs; scanning keeps its place.
      if (state_q == DRIVE && !bus.i_onOff) begin
        sel_q <= ~(4'b0001 << idx_q);
        val_q <= drv_val;
        off_q <= drv_off;
      end else begin
        sel_q <= 4'hf;
        val_q <= 4'h0;
        off_q <= 1'b1;
      end
    end
  end

  assign bus.o_digit_sel = sel_q;
  assign bus.o_value     = val_q;
  assign bus.o_onOff     = off_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with an 8-cycle slot and 2 blank
// cycles; a frame is 32 clocks. Comments give the frame cycle the outputs show.
module tb_fnd_scan_controller;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic lz;

  fnd_scan_controller_if bus ();

  fnd_scan_controller #(
    .P_SCAN_DIV     (8),
    .P_BLANK_CYCLES (2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] sel,
                     input logic [3:0] val, input logic off);
    n_vec++;
    assert ({bus.o_digit_sel, bus.o_value, bus.o_onOff} === {sel, val, off})
    else begin
      n_err++;
      $error("FAIL %s: observed sel=%b value=%h onOff=%b expected sel=%b value=%h onOff=%b",
             tag, bus.o_digit_sel, bus.o_value, bus.o_onOff, sel, val, off);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef FND_LEAD_ZERO_BLANK_EN
    lz = 1'b1;
`else
    lz = 1'b0;
`endif
    rst = 1'b0;
    bus.i_value = 14'd0;
    bus.i_onOff = 1'b0;

    // Reset and scan of 1234
    step(3);  chk("reset",       4'hf, 4'h0, 1'b1);
    rst = 1'b1;
    bus.i_value = 14'd1234;
    step(1);  chk("f0_blank",    4'hf, 4'h0, 1'b1);   // fc 0
    step(1);  chk("f1_blank",    4'hf, 4'h0, 1'b1);   // fc 1
    step(1);  chk("d0_first",    4'b1110, 4'd4, 1'b0); // fc 2
    step(5);  chk("d0_last",     4'b1110, 4'd4, 1'b0); // fc 7
    step(1);  chk("d1_blank",    4'hf, 4'h0, 1'b1);   // fc 8
    step(2);  chk("d1_1234",     4'b1101, 4'd3, 1'b0); // fc 10

    // Snapshot: change mid-frame does not tear
    bus.i_value = 14'd5678;
    step(8);  chk("d2_1234",     4'b1011, 4'd2, 1'b0); // fc 18
    step(8);  chk("d3_1234",     4'b0111, 4'd1, 1'b0); // fc 26
    step(6);  chk("frame_blank", 4'hf, 4'h0, 1'b1);   // fc 32
    step(2);  chk("d0_5678",     4'b1110, 4'd8, 1'b0); // fc 34
    step(8);  chk("d1_5678",     4'b1101, 4'd7, 1'b0); // fc 42
    step(8);  chk("d2_5678",     4'b1011, 4'd6, 1'b0); // fc 50
    step(8);  chk("d3_5678",     4'b0111, 4'd5, 1'b0); // fc 58

    // Overflow
    bus.i_value = 14'd10000;
    step(8);  chk("ovf_d0",      4'b1110, 4'ha, 1'b0); // fc 66
    step(8);  chk("ovf_d1",      4'b1101, 4'ha, 1'b0); // fc 74
    step(8);  chk("ovf_d2",      4'b1011, 4'ha, 1'b0); // fc 82
    step(8);  chk("ovf_d3",      4'b0111, 4'ha, 1'b0); // fc 90
    bus.i_value = 14'd1234;
    step(5);  chk("ovf_d3_last", 4'b0111, 4'ha, 1'b0); // fc 95
    step(1);  chk("ovf_wrap",    4'hf, 4'h0, 1'b1);   // fc 96

    // Display off during idx2, release during idx3
    step(18); chk("off_pre",     4'b1011, 4'd2, 1'b0); // fc 114
    bus.i_onOff = 1'b1;
    step(1);  chk("off_next",    4'hf, 4'h0, 1'b1);   // fc 115
    step(3);  chk("off_hold",    4'hf, 4'h0, 1'b1);   // fc 118
    step(2);  chk("off_d3_c0",   4'hf, 4'h0, 1'b1);   // fc 120
    bus.i_onOff = 1'b0;
    step(1);  chk("rel_c1",      4'hf, 4'h0, 1'b1);   // fc 121
    step(1);  chk("rel_c2",      4'b0111, 4'd1, 1'b0); // fc 122
    step(5);  chk("rel_c7",      4'b0111, 4'd1, 1'b0); // fc 127

    // Leading zeros: 7 then 0
    bus.i_value = 14'd7;
    step(3);  chk("v7_d0",       4'b1110, 4'd7, 1'b0); // fc 130
    step(8);  chk("v7_d1",       4'b1101, 4'd0, lz);   // fc 138
    step(8);  chk("v7_d2",       4'b1011, 4'd0, lz);   // fc 146
    step(8);  chk("v7_d3",       4'b0111, 4'd0, lz);   // fc 154
    bus.i_value = 14'd0;
    step(8);  chk("v0_d0",       4'b1110, 4'd0, 1'b0); // fc 162
    step(8);  chk("v0_d1",       4'b1101, 4'd0, lz);   // fc 170
    step(16); chk("v0_d3",       4'b0111, 4'd0, lz);   // fc 186
    bus.i_value = 14'd1234;

    // Reset mid-frame during idx2 drive
    step(24); chk("rst_pre",     4'b1011, 4'd2, 1'b0); // fc 210
    rst = 1'b0;
    bus.i_value = 14'd5678;
    step(1);  chk("rst_mid",     4'hf, 4'h0, 1'b1);
    rst = 1'b1;
    step(1);  chk("rst_f0",      4'hf, 4'h0, 1'b1);
    step(2);  chk("rst_d0",      4'b1110, 4'd8, 1'b0);
    step(8);  chk("rst_d1",      4'b1101, 4'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
